// File: rtl/alu_sweep_pkg.sv
// Shared types and helpers for the ALU opcode sweep driver.
// The optional running checksum output is enabled with ALU_SWEEP_CHECKSUM_EN.
package alu_sweep_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_OPW    = 4;
    localparam int DEF_SETTLE = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_WAIT,
        PRESENT,
        DONE
    } state_t;

    // Next opcode in the sweep, wrapping at 2**opw.
    function automatic logic [31:0] op_inc(input logic [31:0] op, input int unsigned opw);
        logic [31:0] mask;
        mask = (32'd1 << opw) - 32'd1;
        return (op + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/alu_sweep_out_reg.sv
// Holding register for one sweep result on a valid/ready stream.
// valid/ready: a transfer occurs on a clock edge where valid && ready; data stays stable until then.
module alu_sweep_out_reg #(
    parameter int W   = 9,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [W-1:0]   load_data,
    input  logic [OPW-1:0] load_opcode,
    input  logic           ready,
    output logic           valid,
    output logic [W-1:0]   data,
    output logic [OPW-1:0] opcode
);

    logic           valid_q, valid_d;
    logic [W-1:0]   data_q, data_d;
    logic [OPW-1:0] opcode_q, opcode_d;

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        opcode_d = opcode_q;
        if (load) begin
            valid_d  = 1'b1;
            data_d   = load_data;
            opcode_d = load_opcode;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            opcode_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            opcode_q <= opcode_d;
        end
    end

    assign valid  = valid_q;
    assign data   = data_q;
    assign opcode = opcode_q;

endmodule

// File: rtl/alu_sweep_driver.sv
// Latches an operand pair and steps the ALU through an opcode range, streaming each result.
// Define ALU_SWEEP_CHECKSUM_EN to add the sweep_sum running-XOR output.
module alu_sweep_driver
    import alu_sweep_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int OPW    = DEF_OPW,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [OPW-1:0]   op_first,
    input  logic [OPW-1:0]   op_last,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             carryout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_data,
    output logic [OPW-1:0]   res_opcode,
    output logic             busy,
    output logic             done
`ifdef ALU_SWEEP_CHECKSUM_EN
    ,
    output logic [WIDTH:0]   sweep_sum
`endif
);

    localparam int CW = $clog2(SETTLE + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   opcode_q, opcode_d, last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load;
    logic             res_hs;

    assign res_hs = res_valid && res_ready;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opcode_d = opcode_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a_in;
                    b_d      = b_in;
                    opcode_d = op_first;
                    last_d   = op_last;
                    cnt_d    = CW'(SETTLE);
                    state_d  = SETTLE_WAIT;
                end
            end
            SETTLE_WAIT: begin
                // Capture on the edge where the counter reaches zero.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (res_hs) begin
                    if (opcode_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        opcode_d = OPW'(op_inc(32'(opcode_q), OPW));
                        cnt_d    = CW'(SETTLE);
                        state_d  = SETTLE_WAIT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opcode_q <= opcode_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    alu_sweep_out_reg #(
        .W   (WIDTH + 1),
        .OPW (OPW)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_data   ({carryout, alu_out}),
        .load_opcode (opcode_q),
        .ready       (res_ready),
        .valid       (res_valid),
        .data        (res_data),
        .opcode      (res_opcode)
    );

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = opcode_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

`ifdef ALU_SWEEP_CHECKSUM_EN
    logic [WIDTH:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = '0;
        end else if (res_hs) begin
            sum_d = sum_q ^ res_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sweep_sum = sum_q;
`endif

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed and randomized sweeps of alu_sweep_driver against a queue-based reference model.
// Define ALU_SWEEP_CHECKSUM_EN to also check the sweep_sum output.
module tb_alu_sweep_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [3:0] op_first = '0;
    logic [3:0] op_last = '0;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_out;
    logic       carryout;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [8:0] res_data;
    logic [3:0] res_opcode;
    logic       busy, done;
`ifdef ALU_SWEEP_CHECKSUM_EN
    logic [8:0] sweep_sum;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    logic [8:0] exp_q[$];
    logic [3:0] exp_op_q[$];
    logic [8:0] exp_sum;

    // clock / reset
    always #5 clk = ~clk;

    // ALU stand-in: result is the opcode, carry is its LSB
    assign alu_out  = {4'b0, alu_opcode};
    assign carryout = alu_opcode[0];

    alu_sweep_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .op_first   (op_first),
        .op_last    (op_last),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .carryout   (carryout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_opcode (res_opcode),
        .busy       (busy),
        .done       (done)
`ifdef ALU_SWEEP_CHECKSUM_EN
        ,
        .sweep_sum  (sweep_sum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: list every result the sweep must deliver, in order.
    task automatic build_exp(input int first, input int last);
        int op;
        int steps;
        exp_q.delete();
        exp_op_q.delete();
        exp_sum = '0;
        op = first;
        steps = 0;
        while (steps < 16) begin
            exp_q.push_back(9'((op % 2) * 256 + op));
            exp_op_q.push_back(4'(op));
            exp_sum = exp_sum ^ 9'((op % 2) * 256 + op);
            steps++;
            if (op == last) break;
            op = (op + 1) % 16;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_data"}, 32'(res_data), 32'd0);
        check({tag, "_resop"}, 32'(res_opcode), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_opcode), 32'd0);
`ifdef ALU_SWEEP_CHECKSUM_EN
        check({tag, "_sum"}, 32'(sweep_sum), 32'd0);
`endif
    endtask

    task automatic issue_start(input logic [7:0] a, input logic [7:0] b, input int first, input int last);
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        op_first = 4'(first);
        op_last  = 4'(last);
        start    = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_novalid", 32'(res_valid), 32'd0);
        check("start_alu_op", 32'(alu_opcode), 32'(first));
        check("start_alu_a", 32'(alu_a), 32'(a));
        // operands must already be latched, so later input changes are irrelevant
        a_in = 8'($urandom);
        b_in = 8'($urandom);
    endtask

    // driver + scoreboard for one sweep
    task automatic sweep(input logic [7:0] a, input logic [7:0] b, input int first, input int last,
                         input int ready_pct, input int stall_idx, input bit poke);
        int  n;
        int  idx = 0;
        int  stall = 0;
        int  cyc = 0;
        int  done_cyc = -1;
        int  first_valid = -1;
        bit  rdy;
        build_exp(first, last);
        n = exp_q.size();
        issue_start(a, b, first, last);
        while (cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (res_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check("alu_a_hold", 32'(alu_a), 32'(a));
                check("alu_b_hold", 32'(alu_b), 32'(b));
                if (exp_q.size() == 0) begin
                    check("extra_result", 32'(res_valid), 32'd0);
                    rdy = 1'b1;
                end else begin
                    check("res_data", 32'(res_data), 32'(exp_q[0]));
                    check("res_opcode", 32'(res_opcode), 32'(exp_op_q[0]));
                    check("alu_opcode", 32'(alu_opcode), 32'(exp_op_q[0]));
                    if (idx == stall_idx && stall < 5) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = ($urandom_range(0, 99) < ready_pct);
                    end
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        void'(exp_op_q.pop_front());
                        idx++;
                    end
                end
                res_ready = rdy;
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
            if (poke && (cyc % 3 == 1)) begin
                start    = 1'b1;
                a_in     = 8'($urandom);
                b_in     = 8'($urandom);
                op_first = 4'($urandom);
                op_last  = 4'($urandom);
            end
            cyc++;
        end
        start = 1'b0;
        res_ready = 1'b0;
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        check("result_count", 32'(idx), 32'(n));
        check("busy_in_done", 32'(busy), 32'd1);
        check("first_valid_lat", 32'(first_valid), 32'd0);
        if (ready_pct == 100 && stall_idx < 0)
            check("throughput", 32'(done_cyc), 32'(2 * n - 1));
        if (ready_pct == 100 && stall_idx >= 0)
            check("stall_len", 32'(done_cyc), 32'(2 * n - 1 + 5));
`ifdef ALU_SWEEP_CHECKSUM_EN
        check("sum_at_done", 32'(sweep_sum), 32'(exp_sum));
`endif
        @(negedge clk);
        check("done_pulse_1", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_novalid", 32'(res_valid), 32'd0);
`ifdef ALU_SWEEP_CHECKSUM_EN
        check("sum_held", 32'(sweep_sum), 32'(exp_sum));
`endif
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_all_zero("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // full sweep, constant ready
        sweep(8'd10, 8'd5, 0, 15, 100, -1, 1'b0);
        // wrap-around range
        sweep(8'd10, 8'd5, 14, 1, 100, -1, 1'b0);
        // five cycles of back-pressure on result 3
        sweep(8'h3c, 8'hc3, 0, 15, 100, 3, 1'b0);
        // single opcode with start pulses while busy
        sweep(8'h11, 8'h22, 7, 7, 100, -1, 1'b1);
        // wrap with start pulses and random ready
        sweep(8'h44, 8'h55, 12, 3, 60, -1, 1'b1);

        // asynchronous reset while a result is held
        build_exp(0, 15);
        issue_start(8'd10, 8'd5, 0, 15);
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        check("reached_present", 32'(res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        check("rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");
        sweep(8'd10, 8'd5, 0, 15, 100, -1, 1'b0);

        // randomized sweeps
        for (int k = 0; k < 8; k++) begin
            sweep(8'($urandom), 8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(30, 100)), int'($urandom_range(0, 1)) == 1 ? int'($urandom_range(0, 3)) : -1,
                  1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sweep_driver.md
Name: alu_sweep_driver

Overview:
- Initiator side of the ALU operand/opcode interface: latches one operand pair and issues a run of opcodes to the combinational ALU.
- Waits a fixed settle time per opcode, captures {carryout, alu_out} and presents each result on a valid/ready stream.
- Sits between a command source (CPU/bench sequencer) and the `alu` instance; replaces hand-timed opcode stepping with a clocked, back-pressured sweep.

Parameters:
- WIDTH, 8, operand/result width.
- OPW, 4, opcode width; 2**OPW opcodes.
- SETTLE, 1, cycles (>=1) between driving an opcode and sampling the ALU result.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- a_in  in  WIDTH  operand A, latched on accepted start.
- b_in  in  WIDTH  operand B, latched on accepted start.
- op_first  in  OPW  first opcode, latched on start.
- op_last  in  OPW  last opcode, latched on start.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_opcode  out  OPW  to ALU opcode.
- alu_out  in  WIDTH  from ALU result.
- carryout  in  1  from ALU carry.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH+1  {carry, result}.
- res_opcode  out  OPW  opcode that produced res_data.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE.
  - Settle counter and latched operands cleared.
  - Effective immediately, including mid-sweep.
  - Any in-flight result is discarded; no done pulse.
- FSM states: IDLE, SETTLE_WAIT, PRESENT, DONE.
- IDLE:
  - On start=1: latch a_in, b_in, op_first, op_last.
  - Drive alu_a/alu_b/alu_opcode=op_first from the next cycle; load counter=SETTLE; go to SETTLE_WAIT.
- SETTLE_WAIT:
  - Counter decrements each cycle.
  - When it reaches 0: register res_data={carryout, alu_out} and res_opcode=alu_opcode; assert res_valid; go to PRESENT.
  - With SETTLE=1, first res_valid occurs 2 cycles after the start cycle.
- PRESENT:
  - res_valid, res_data and res_opcode are held stable until res_valid&&res_ready.
  - alu_* outputs stay constant.
  - On handshake: if alu_opcode==op_last, go to DONE. Otherwise alu_opcode increments mod 2**OPW, counter reloads, go to SETTLE_WAIT.
  - res_valid drops the cycle after the handshake.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy drops in the same cycle as the IDLE entry.
- Opcode range rules:
  - Wrap-around: op_first>op_last sweeps through 2**OPW-1 to 0 and then to op_last. Example: 14,15,0,1 for first=14, last=1.
  - op_first==op_last issues a single opcode.
  - Full sweep uses first=0, last=2**OPW-1 and gives 16 results for OPW=4.
- start while busy is ignored; latched operands are unaffected.
- res_ready asserted without res_valid has no effect. Back-pressure of any length is legal.
- Throughput with SETTLE=1 and res_ready held high: one result every 2 cycles.

Optional Feature:
- Macro: ALU_SWEEP_CHECKSUM_EN.
- Defined:
  - Adds output sweep_sum [WIDTH:0].
  - Running XOR of every accepted res_data. Cleared on accepted start and on reset.
  - Final value is valid from the done cycle and held until the next start.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package alu_sweep_pkg:
  - state enum (IDLE, SETTLE_WAIT, PRESENT, DONE).
  - default WIDTH/OPW/SETTLE localparams.
  - opcode-increment-with-wrap function.
- One natural sub-module: alu_sweep_out_reg, the valid/ready holding register for res_data/res_opcode.
- FSM and counter stay in the top module.

Test Plan:
- Bench ALU model: alu_out={4'b0,opcode}, carryout=opcode[0].
- Full sweep: a_in=10, b_in=5, first=0, last=15, res_ready=1 -> 16 results with res_opcode 0..15 in order and res_data={op[0],op}. alu_a=10 and alu_b=5 throughout. First res_valid 2 cycles after start. done pulses once, then busy=0.
- Wrap: first=14, last=1 -> res_opcode sequence 14,15,0,1, then done.
- Back-pressure: res_ready low for 5 cycles on result 3 -> res_data/res_opcode stable and alu_opcode unchanged; sequence resumes without loss or duplication.
- Single op and ignored start: first=last=7 -> exactly one result (res_data=9'h107), then done. start pulsed mid-sweep changes nothing.
- Reset mid-sweep: rst_n low while in PRESENT -> all outputs 0 asynchronously, no done. Next start runs a clean sweep.
- With ALU_SWEEP_CHECKSUM_EN, sweep 0..15 -> sweep_sum = XOR of {op[0],op} over all op = 9'h000 at done.
